// File: rtl/simon_pkg.sv
// ============================================================================
// simon_pkg : shared direction codes, checker state encoding and defaults
// Revision  : 1.0
// ============================================================================
`default_nettype none

package simon_pkg;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    localparam int STEPS_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_PASS    = 2'd2,
        ST_FAIL    = 2'd3
    } chk_state_e;

    // Direction code of a one-hot key vector (bit index == direction code).
    function automatic logic [1:0] dir_of(input logic [3:0] press);
        logic [1:0] code;
        code = DIR_UP;
        if (press[1]) code = DIR_DOWN;
        if (press[2]) code = DIR_LEFT;
        if (press[3]) code = DIR_RIGHT;
        return code;
    endfunction

endpackage

`default_nettype wire

// File: rtl/key_edge_detect.sv
// ============================================================================
// key_edge_detect : 2-flop synchroniser per key followed by a registered
//                   rising-edge detector producing one-cycle press pulses
// Revision        : 1.0
// ============================================================================
`default_nettype none

module key_edge_detect #(
    parameter int WIDTH = 4
) (
    input  logic             clock_i,
    input  logic             reset_n_i,
    input  logic [WIDTH-1:0] keys_i,
    output logic [WIDTH-1:0] press_o
);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] press_q;

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            press_q <= '0;
        end else begin
            sync1_q <= keys_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            press_q <= sync2_q & ~prev_q;
        end
    end

    assign press_o = press_q;

endmodule

`default_nettype wire

// File: rtl/player_input_checker.sv
// ============================================================================
// player_input_checker : compares the player's button presses against the
//                        latched direction sequence and reports pass/fail.
//                        Optional inactivity timeout: SIMON_INPUT_TIMEOUT_EN
// Revision             : 1.0
// ============================================================================
`default_nettype none

module player_input_checker
    import simon_pkg::*;
#(
    parameter int STEPS          = STEPS_DEF,
    parameter int TIMEOUT_CYCLES = 50_000_000,
    parameter int TO_W           = 26
) (
    input  logic               clock_i,
    input  logic               reset_n_i,
    input  logic               start_i,
    input  logic [2*STEPS-1:0] sequence_i,
    input  logic [3:0]         keys_i,
    output logic               busy_o,
    output logic               pass_o,
    output logic               fail_o,
    output logic               timed_out_o,
    output logic [2:0]         step_o
);

    logic [3:0]         press;
    logic               start_q;
    logic               start_pulse;
    logic               timeout_hit;
    logic [1:0]         exp_code;

    chk_state_e         state_q;
    logic [2*STEPS-1:0] seq_q;
    logic [2:0]         step_q;
    logic               busy_q;
    logic               pass_q;
    logic               fail_q;
    logic               timed_out_q;

    key_edge_detect #(
        .WIDTH (4)
    ) u_key_edge_detect (
        .clock_i   (clock_i),
        .reset_n_i (reset_n_i),
        .keys_i    (keys_i),
        .press_o   (press)
    );

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            start_q <= 1'b0;
        end else begin
            start_q <= start_i;
        end
    end

    assign start_pulse = start_i & ~start_q;

    always_comb begin
        exp_code = DIR_UP;
        for (int i = 0; i < STEPS; i++) begin
            if (step_q == 3'(i)) begin
                exp_code = seq_q[2*STEPS-1-2*i -: 2];
            end
        end
    end

`ifdef SIMON_INPUT_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt_q;

    assign timeout_hit = (state_q == ST_COLLECT) &&
                         (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    // Restarts on round entry and on every press; idle outside COLLECT.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            to_cnt_q <= '0;
        end else if (start_pulse || (state_q != ST_COLLECT) || (press != 4'b0000)) begin
            to_cnt_q <= '0;
        end else if (!timeout_hit) begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0) && (TO_W > 0);
    assign timeout_hit        = 1'b0;
`endif

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= ST_IDLE;
            seq_q       <= '0;
            step_q      <= 3'd0;
            busy_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            timed_out_q <= 1'b0;
        end else if (start_pulse) begin
            state_q     <= ST_COLLECT;
            seq_q       <= sequence_i;
            step_q      <= 3'd0;
            busy_q      <= 1'b1;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            timed_out_q <= 1'b0;
        end else if (state_q == ST_COLLECT) begin
            if (press != 4'b0000) begin
                if ($onehot(press) && (dir_of(press) == exp_code)) begin
                    if (step_q == 3'(STEPS - 1)) begin
                        state_q <= ST_PASS;
                        step_q  <= 3'(STEPS);
                        busy_q  <= 1'b0;
                        pass_q  <= 1'b1;
                    end else begin
                        step_q  <= step_q + 3'd1;
                    end
                end else begin
                    state_q <= ST_FAIL;
                    busy_q  <= 1'b0;
                    fail_q  <= 1'b1;
                end
            end else if (timeout_hit) begin
                state_q     <= ST_FAIL;
                busy_q      <= 1'b0;
                fail_q      <= 1'b1;
                timed_out_q <= 1'b1;
            end
        end
    end

    assign busy_o      = busy_q;
    assign pass_o      = pass_q;
    assign fail_o      = fail_q;
    assign timed_out_o = timed_out_q;
    assign step_o      = step_q;

endmodule

`default_nettype wire

// File: tb/tb_player_input_checker.sv
// ============================================================================
// tb_player_input_checker : directed table-driven bench for player_input_checker
// Revision                : 1.0
// ============================================================================
`default_nettype none

module tb_player_input_checker;

    logic       clock;
    logic       reset_n;
    logic       start;
    logic [7:0] seq;
    logic [3:0] keys;
    logic       busy;
    logic       pass;
    logic       fail;
    logic       timed_out;
    logic [2:0] step;

    int total = 0;
    int bad   = 0;

    player_input_checker #(
        .STEPS          (4),
        .TIMEOUT_CYCLES (100),
        .TO_W           (8)
    ) dut (
        .clock_i     (clock),
        .reset_n_i   (reset_n),
        .start_i     (start),
        .sequence_i  (seq),
        .keys_i      (keys),
        .busy_o      (busy),
        .pass_o      (pass),
        .fail_o      (fail),
        .timed_out_o (timed_out),
        .step_o      (step)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] sq;
        int         n;
        logic [3:0] ks [4];
        logic [2:0] exp_step;
        logic       exp_pass;
        logic       exp_fail;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all_idle(input string name);
        chk({name, ".busy"}, 32'(busy), 32'd0);
        chk({name, ".pass"}, 32'(pass), 32'd0);
        chk({name, ".fail"}, 32'(fail), 32'd0);
        chk({name, ".timed_out"}, 32'(timed_out), 32'd0);
        chk({name, ".step"}, 32'(step), 32'd0);
    endtask

    task automatic start_round(input logic [7:0] s);
        @(negedge clock);
        seq   = s;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("start.busy", 32'(busy), 32'd1);
        chk("start.step", 32'(step), 32'd0);
        chk("start.pass", 32'(pass), 32'd0);
        chk("start.fail", 32'(fail), 32'd0);
    endtask

    task automatic press_key(input logic [3:0] k);
        @(negedge clock);
        keys = k;
        repeat (4) @(posedge clock);
        #1;
        @(negedge clock);
        keys = 4'b0000;
        repeat (4) @(negedge clock);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] prev_step;

        vecs[0] = '{8'b00_01_10_11, 4, '{4'b0001, 4'b0010, 4'b0100, 4'b1000}, 3'd4, 1'b1, 1'b0};
        vecs[1] = '{8'b11_11_00_01, 2, '{4'b1000, 4'b0100, 4'b0000, 4'b0000}, 3'd1, 1'b0, 1'b1};
        vecs[2] = '{8'b11_00_00_11, 1, '{4'b0101, 4'b0000, 4'b0000, 4'b0000}, 3'd0, 1'b0, 1'b1};
        vecs[3] = '{8'hE4,          4, '{4'b1000, 4'b0100, 4'b0010, 4'b0001}, 3'd4, 1'b1, 1'b0};
        vecs[4] = '{8'hAA,          4, '{4'b0100, 4'b0100, 4'b0100, 4'b0010}, 3'd3, 1'b0, 1'b1};
        vecs[5] = '{8'h55,          4, '{4'b0010, 4'b0010, 4'b0010, 4'b0010}, 3'd4, 1'b1, 1'b0};

        reset_n = 1'b0;
        start   = 1'b0;
        seq     = 8'h00;
        keys    = 4'b0000;
        repeat (3) @(negedge clock);
        chk_all_idle("reset");
        reset_n = 1'b1;
        @(negedge clock);

        // Table-driven rounds; step must not move before the fourth edge.
        for (int r = 0; r < 6; r++) begin
            start_round(vecs[r].sq);
            prev_step = 3'd0;
            for (int i = 0; i < vecs[r].n; i++) begin
                @(negedge clock);
                keys = vecs[r].ks[i];
                repeat (3) @(posedge clock);
                #1;
                chk("latency.step", 32'(step), 32'(prev_step));
                chk("latency.pass", 32'(pass), 32'd0);
                @(posedge clock);
                #1;
                if (i < vecs[r].n - 1) begin
                    chk("mid.step", 32'(step), 32'(i + 1));
                    chk("mid.busy", 32'(busy), 32'd1);
                end else begin
                    chk("end.step", 32'(step), 32'(vecs[r].exp_step));
                    chk("end.pass", 32'(pass), 32'(vecs[r].exp_pass));
                    chk("end.fail", 32'(fail), 32'(vecs[r].exp_fail));
                    chk("end.busy", 32'(busy), 32'd0);
                    chk("end.timed_out", 32'(timed_out), 32'd0);
                end
                prev_step = 3'(i + 1);
                @(negedge clock);
                keys = 4'b0000;
                repeat (4) @(negedge clock);
            end
        end

        // Presses after a finished round are ignored.
        press_key(4'b0001);
        chk("post.step", 32'(step), 32'd4);
        chk("post.pass", 32'(pass), 32'd1);

        // Asynchronous reset mid-round, then an ignored press.
        start_round(8'hE4);
        press_key(4'b1000);
        press_key(4'b0100);
        chk("t4.pre.step", 32'(step), 32'd2);
        @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        chk_all_idle("t4.async");
        @(negedge clock);
        reset_n = 1'b1;
        press_key(4'b0001);
        chk_all_idle("t4.after");

        // Restart mid-round with a new sequence; held key gives no press.
        start_round(8'b00_01_10_11);
        press_key(4'b0001);
        chk("t6.step1", 32'(step), 32'd1);
        start_round(8'hE4);
        press_key(4'b1000);
        chk("t6.newseq.step", 32'(step), 32'd1);
        chk("t6.newseq.busy", 32'(busy), 32'd1);
        @(negedge clock);
        keys = 4'b1000;
        repeat (6) @(negedge clock);
        chk("t6.wrongkey.fail", 32'(fail), 32'd1);
        chk("t6.wrongkey.step", 32'(step), 32'd1);
        start_round(8'hE4);
        repeat (8) @(negedge clock);
        chk("t6.held.step", 32'(step), 32'd0);
        chk("t6.held.busy", 32'(busy), 32'd1);
        chk("t6.held.fail", 32'(fail), 32'd0);
        keys = 4'b0000;
        repeat (4) @(negedge clock);
        press_key(4'b1000);
        chk("t6.repress.step", 32'(step), 32'd1);

        // Inactivity: entry edge E, timeout acts at E+100.
        start_round(8'h1B);
`ifdef SIMON_INPUT_TIMEOUT_EN
        repeat (99) @(posedge clock);
        #1;
        chk("t5.before.busy", 32'(busy), 32'd1);
        chk("t5.before.fail", 32'(fail), 32'd0);
        @(posedge clock);
        #1;
        chk("t5.fail", 32'(fail), 32'd1);
        chk("t5.timed_out", 32'(timed_out), 32'd1);
        chk("t5.busy", 32'(busy), 32'd0);
`else
        repeat (1000) @(posedge clock);
        #1;
        chk("t5.busy", 32'(busy), 32'd1);
        chk("t5.fail", 32'(fail), 32'd0);
        chk("t5.timed_out", 32'(timed_out), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
